// File: rtl/au_pkg.sv
// Shared definitions for the add/subtract/compare unit and its arbiter.
package au_pkg;
    localparam int AU_WIDTH = 32;

    localparam logic AU_ADD = 1'b0;
    localparam logic AU_SUB = 1'b1;

    typedef struct packed {
        logic [AU_WIDTH-1:0] out;
        logic                ult;
        logic                slt;
    } au_result_t;
endpackage

// File: rtl/au.sv
// Combinational add/subtract unit with unsigned and signed less-than compares.
module au
    import au_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] ra_i,
    input  logic [WIDTH-1:0] rb_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] out_o,
    output logic             ult_o,
    output logic             slt_o
);
    logic signed [WIDTH-1:0] sra;
    logic signed [WIDTH-1:0] srb;

    assign sra = ra_i;
    assign srb = rb_i;

    assign out_o = (mode_i == AU_SUB) ? (ra_i - rb_i) : (ra_i + rb_i);

    // Compares come from the operands directly, so overflow of the difference cannot corrupt them.
    assign ult_o = (ra_i < rb_i);
    assign slt_o = (sra < srb);
endmodule

// File: rtl/au_arbiter.sv
// Round-robin arbiter sharing one au instance between NREQ requesters,
// with a single registered, ID-tagged response slot.
module au_arbiter
    import au_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_ra,
    input  logic [NREQ*WIDTH-1:0] req_rb,
    input  logic [NREQ-1:0]       req_mode,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_out,
    output logic                  rsp_ult,
    output logic                  rsp_slt
);
    // Returns {found, index} of the first valid requester at or after ptr, wrapping.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  ptr);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (valid[idx]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
    logic             rsp_ult_q, rsp_ult_d;
    logic             rsp_slt_q, rsp_slt_d;

    logic [IDW:0]     pick;
    logic             grant_vld;
    logic [IDW-1:0]   win_id;
    logic             slot_free;
    logic             accept;

    logic [WIDTH-1:0] win_ra;
    logic [WIDTH-1:0] win_rb;
    logic             win_mode;
    logic [WIDTH-1:0] au_out;
    logic             au_ult;
    logic             au_slt;

    assign pick      = rr_pick(req_valid, ptr_q);
    assign grant_vld = pick[IDW];
    assign win_id    = pick[IDW-1:0];
    assign slot_free = !rsp_valid_q || rsp_ready;
    assign accept    = grant_vld && slot_free && rst_n;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win_id] = 1'b1;
    end

    assign win_ra   = req_ra[int'(win_id)*WIDTH +: WIDTH];
    assign win_rb   = req_rb[int'(win_id)*WIDTH +: WIDTH];
    assign win_mode = req_mode[win_id];

    au #(
        .WIDTH (WIDTH)
    ) u_au (
        .ra_i   (win_ra),
        .rb_i   (win_rb),
        .mode_i (win_mode),
        .out_o  (au_out),
        .ult_o  (au_ult),
        .slt_o  (au_slt)
    );

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_out_d   = rsp_out_q;
        rsp_ult_d   = rsp_ult_q;
        rsp_slt_d   = rsp_slt_q;
        if (accept) begin
            ptr_d       = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
            rsp_valid_d = 1'b1;
            rsp_id_d    = win_id;
            rsp_out_d   = au_out;
            // The au compare flags are meaningless for an add and must not be captured.
            rsp_ult_d   = (win_mode == AU_SUB) && au_ult;
            rsp_slt_d   = (win_mode == AU_SUB) && au_slt;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_out_q   <= '0;
            rsp_ult_q   <= 1'b0;
            rsp_slt_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_out_q   <= rsp_out_d;
            rsp_ult_q   <= rsp_ult_d;
            rsp_slt_q   <= rsp_slt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_ult   = rsp_ult_q;
    assign rsp_slt   = rsp_slt_q;
endmodule

// File: tb/tb_au_arbiter.sv
// Bench for au_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_au_arbiter;
    localparam int WIDTH = 32;
    localparam int NREQ  = 2;
    localparam int IDW   = 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_ra;
    logic [NREQ*WIDTH-1:0] req_rb;
    logic [NREQ-1:0]       req_mode;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_out;
    logic                  rsp_ult;
    logic                  rsp_slt;

    int checks   = 0;
    int failures = 0;

    au_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ra    (req_ra),
        .req_rb    (req_rb),
        .req_mode  (req_mode),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .rsp_ult   (rsp_ult),
        .rsp_slt   (rsp_slt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic m);
        req_ra[i*WIDTH +: WIDTH] = a;
        req_rb[i*WIDTH +: WIDTH] = b;
        req_mode[i] = m;
    endtask

    task automatic drive_edge();
        @(posedge clk); #1;
    endtask

    task automatic sample_edge();
        @(negedge clk); #1;
    endtask

    // Behavioural model: state as of the latest rising edge, plus what the next edge will commit.
    int               m_ptr;
    logic             m_vld;
    int               m_id;
    logic [WIDTH-1:0] m_out;
    logic             m_ult, m_slt;
    logic             pend;
    int               p_ptr;
    logic             p_vld;
    int               p_id;
    logic [WIDTH-1:0] p_out;
    logic             p_ult, p_slt;

    always @(negedge clk) begin : cmp
        int               w;
        logic [NREQ-1:0]  exp_rdy;
        logic             free;
        logic [WIDTH-1:0] a, b;
        if (!rst_n) begin
            m_ptr = 0; m_vld = 1'b0; m_id = 0; m_out = '0; m_ult = 1'b0; m_slt = 1'b0;
            pend = 1'b0;
            check("m_rst_ready", 64'(req_ready), 64'(0));
            check("m_rst_valid", 64'(rsp_valid), 64'(0));
        end else begin
            if (pend) begin
                m_ptr = p_ptr; m_vld = p_vld; m_id = p_id;
                m_out = p_out; m_ult = p_ult; m_slt = p_slt;
            end
            free = !m_vld || rsp_ready;
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            exp_rdy = (w >= 0 && free) ? NREQ'(1 << w) : '0;
            check("m_req_ready", 64'(req_ready), 64'(exp_rdy));
            check("m_rsp_valid", 64'(rsp_valid), 64'(m_vld));
            check("m_rsp_id",    64'(rsp_id),    64'(m_id));
            check("m_rsp_out",   64'(rsp_out),   64'(m_out));
            check("m_rsp_ult",   64'(rsp_ult),   64'(m_ult));
            check("m_rsp_slt",   64'(rsp_slt),   64'(m_slt));
            p_ptr = m_ptr; p_vld = m_vld; p_id = m_id;
            p_out = m_out; p_ult = m_ult; p_slt = m_slt;
            if (w >= 0 && free) begin
                a = req_ra[w*WIDTH +: WIDTH];
                b = req_rb[w*WIDTH +: WIDTH];
                p_vld = 1'b1;
                p_id  = w;
                p_ptr = (w + 1) % NREQ;
                if (req_mode[w]) begin
                    p_out = a - b;
                    p_ult = a < b;
                    p_slt = $signed(a) < $signed(b);
                end else begin
                    p_out = a + b;
                    p_ult = 1'b0;
                    p_slt = 1'b0;
                end
            end else if (rsp_ready) begin
                p_vld = 1'b0;
            end
            pend = 1'b1;
        end
    end

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        pend = 1'b0;
        rst_n = 1'b0;
        req_valid = 2'b01;
        req_ra = '0; req_rb = '0; req_mode = '0;
        rsp_ready = 1'b0;

        // Reset holds ready low even with a valid request
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        drive_edge();
        rst_n = 1'b1; req_valid = 2'b00;

        // Single subtract from requester 0
        drive_edge();
        set_req(0, 32'd5, 32'd7, 1'b1); req_valid = 2'b01; rsp_ready = 1'b1;
        sample_edge();
        check("t1_ready", 64'(req_ready), 64'(2'b01));
        drive_edge();
        req_valid = 2'b00;
        sample_edge();
        check("t1_valid", 64'(rsp_valid), 64'(1));
        check("t1_id",    64'(rsp_id),    64'(0));
        check("t1_out",   64'(rsp_out),   64'(32'hFFFF_FFFE));
        check("t1_ult",   64'(rsp_ult),   64'(1));
        check("t1_slt",   64'(rsp_slt),   64'(1));

        // Add mode gates the compare flags
        drive_edge();
        set_req(1, 32'hFFFF_FFFF, 32'd1, 1'b0); req_valid = 2'b10;
        sample_edge();
        check("t2_ready", 64'(req_ready), 64'(2'b10));
        drive_edge();
        req_valid = 2'b00;
        sample_edge();
        check("t2_id",  64'(rsp_id),  64'(1));
        check("t2_out", 64'(rsp_out), 64'(0));
        check("t2_ult", 64'(rsp_ult), 64'(0));
        check("t2_slt", 64'(rsp_slt), 64'(0));

        // Round-robin alternation with both requesters always valid
        set_req(0, 32'd10, 32'd3, 1'b1);
        set_req(1, 32'd100, 32'd200, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive_edge();
            req_valid = 2'b11; rsp_ready = 1'b1;
            sample_edge();
            check("t3_grant", 64'(req_ready), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
            if (k > 0) check("t3_id", 64'(rsp_id), 64'((k - 1) % 2));
        end

        // Backpressure: slot holds requester 1's sum, nothing is granted
        drive_edge();
        rsp_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sample_edge();
            check("t4_ready", 64'(req_ready), 64'(0));
            check("t4_valid", 64'(rsp_valid), 64'(1));
            check("t4_id",    64'(rsp_id),    64'(1));
            check("t4_out",   64'(rsp_out),   64'(300));
            drive_edge();
        end
        rsp_ready = 1'b1;
        sample_edge();
        check("t4_resume", 64'(req_ready), 64'(2'b01));
        drive_edge();
        req_valid = 2'b00;
        sample_edge();
        check("t4_id2",  64'(rsp_id),  64'(0));
        check("t4_out2", 64'(rsp_out), 64'(7));

        // Signed versus unsigned compare
        drive_edge();
        set_req(0, 32'h8000_0000, 32'd1, 1'b1); req_valid = 2'b01;
        drive_edge();
        req_valid = 2'b00;
        sample_edge();
        check("t5_out", 64'(rsp_out), 64'(32'h7FFF_FFFF));
        check("t5_ult", 64'(rsp_ult), 64'(0));
        check("t5_slt", 64'(rsp_slt), 64'(1));

        // Asynchronous reset while a stalled response is pending
        drive_edge();
        set_req(0, 32'd3, 32'd3, 1'b1); req_valid = 2'b01; rsp_ready = 1'b1;
        drive_edge();
        req_valid = 2'b00; rsp_ready = 1'b0;
        sample_edge();
        check("t6_pre_valid", 64'(rsp_valid), 64'(1));
        #1;
        req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 64'(rsp_valid), 64'(0));
        check("t6_async_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        drive_edge();
        rst_n = 1'b1; rsp_ready = 1'b1;
        sample_edge();
        check("t6_ptr_reset", 64'(req_ready), 64'(2'b01));

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 600; c++) begin
            drive_edge();
            req_valid = NREQ'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
            end
        end
        drive_edge();
        req_valid = '0;
        sample_edge();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/au_arbiter.md
Name: au_arbiter

Overview:
Shares one `au` add/subtract/compare instance between NREQ requesters, e.g. the execute-stage ALU path and the branch-compare path. Selection is round-robin. Each requester port uses a valid/ready handshake, and the chosen operation's result is captured into a single-entry registered response slot. Each response is tagged with the ID of the requester that issued it, so the pipeline can route results back.

Parameters:
WIDTH, 32, operand/result width passed to the `au` instance
NREQ, 2, number of requesters (allowed range 2..8)
IDW, (NREQ>1 ? $clog2(NREQ) : 1), requester ID width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operation valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_ra  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
req_rb  in  NREQ*WIDTH  operand B, same packing as req_ra
req_mode  in  NREQ  0 = add, 1 = subtract/compare
rsp_valid  out  1  response slot holds a result
rsp_ready  in  1  consumer accepts the response
rsp_id  out  IDW  index of the requester that issued the response
rsp_out  out  WIDTH  sum or difference
rsp_ult  out  1  unsigned ra<rb; 0 when mode=0
rsp_slt  out  1  signed ra<rb; 0 when mode=0

Behaviour:
- State:
  - ptr (IDW bits): priority pointer.
  - Response slot registers: rsp_valid, rsp_id, rsp_out, rsp_ult, rsp_slt.
- Reset (asynchronous, rst_n=0):
  - ptr=0, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_ult=0, rsp_slt=0.
  - A response pending when reset asserts is discarded.
  - req_ready=0 while rst_n=0.
- Slot free: slot_free = !rsp_valid || rsp_ready.
- Arbitration (combinational, every cycle):
  - Winner w = first index i with req_valid[i]=1, scanning ptr, ptr+1, ... with wrap modulo NREQ.
  - req_ready[w]=1 only if slot_free; every other req_ready bit is 0.
  - No valid requester → req_ready all 0.
- Datapath:
  - The winner's ra, rb and mode are muxed into the `au` instance.
  - Compare outputs are forced to 0 when mode=0; the `au` compare outputs are don't-care in add mode and must never reach a register.
- Accept (req_valid[w] && req_ready[w] at the clock edge):
  - rsp_valid←1, rsp_id←w, rsp_out/ult/slt←au result.
  - ptr←(w+1) mod NREQ. For non-power-of-2 NREQ, wrap explicitly; never let ptr reach values ≥ NREQ.
- Latency: accept at edge N → rsp_valid=1 in the cycle after edge N. Throughput is one operation per cycle while rsp_ready=1.
- Simultaneous drain and fill: rsp_ready=1 with rsp_valid=1 and a new accept in the same cycle → the slot is overwritten with the new result and rsp_valid stays 1.
- Drain only: rsp_ready=1 with no accept → rsp_valid←0 next edge.
- Stall: rsp_valid=1 and rsp_ready=0:
  - All rsp_* outputs hold stable.
  - req_ready all 0.
  - ptr unchanged.
- Requester obligations: hold req_valid and operands stable until ready is seen. The arbiter does not depend on this; arbitration is recomputed every cycle and nothing is locked.
- Dependencies:
  - req_ready depends combinationally on req_valid and rsp_ready.
  - rsp_* outputs are registered only; there is no combinational path from req_* to rsp_*.
- Arithmetic:
  - Add and subtract wrap modulo 2^WIDTH.
  - ult compares operands as unsigned; slt compares them as two's complement.
  - Both compares are taken from the operands, not from the difference.

Decomposition:
- Shared package (au_pkg): AU_ADD=1'b0 and AU_SUB=1'b1 mode constants, plus a packed au_result_t struct {out, ult, slt} parameterised via WIDTH localparam.
- One sub-module: the existing `au`, instantiated once. The rotating-priority pick may be a function inside au_arbiter; no separate module.

Test Plan:
1. Reset, then a single request: hold rst_n=0 with req_valid=2'b01 → req_ready=0 and rsp_valid=0. Release reset, then present req0 ra=5, rb=7, mode=1 → next cycle rsp_valid=1, rsp_id=0, rsp_out=0xFFFFFFFE, rsp_ult=1, rsp_slt=1.
2. Add mode compare gating: req1 ra=0xFFFFFFFF, rb=1, mode=0 → rsp_out=0, rsp_ult=0, rsp_slt=0, rsp_id=1.
3. Round-robin fairness: both requesters hold valid for 4 cycles with rsp_ready=1 → grants alternate 0,1,0,1. rsp_id sequence 0,1,0,1 appears one cycle later.
4. Backpressure: rsp_ready=0 for 3 cycles with both requesters valid:
   - rsp_* outputs hold the first result.
   - req_ready=0 throughout; ptr does not advance.
   - On rsp_ready=1, the next grant goes to the requester after the last winner.
5. Signed versus unsigned compare: ra=0x80000000, rb=1, mode=1 → rsp_ult=0, rsp_slt=1, rsp_out=0x7FFFFFFF.
6. Reset mid-stream: assert rst_n=0 asynchronously while rsp_valid=1 and rsp_ready=0 → rsp_valid drops immediately, with no clock edge. After release, ptr=0, so req0 wins when both requesters are valid.
